// File: rtl/mr_wb_ram.sv
// rtl/mr_wb_ram.sv - pipelined Wishbone B4 slave wrapping a single-port word RAM
//
// Purpose: data memory / scratchpad responder for the load/store unit. It
// supports byte-lane writes, full-word reads and a fixed number of wait states
// per access, with stall_o back-pressure. At most one access is outstanding.
//
// Optional feature macro: MR_WB_RAM_ERR_EN
//   defined   -> addresses with any bit set above the RAM index get err_o and
//                do not touch memory or dat_o
//   undefined -> upper address bits are ignored (aliasing), err_o is tied to 0
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous active-high reset
//   addr_i   in   word address, bits [XLEN-1:XLEN_GRAN]
//   we_i     in   1 = write, 0 = read
//   sel_i    in   byte-lane enables for writes
//   dat_i    in   write data
//   stb_i    in   request strobe
//   cyc_i    in   bus cycle active; also gates responses and aborts pending work
//   ack_o    out  access completed
//   err_o    out  access failed (out of range)
//   stall_o  out  request not accepted this cycle
//   dat_o    out  read data, holds its value between reads
//
// DEPTH_WORDS must be a power of two and at least 2; WAIT_STATES is 0..15.
module mr_wb_ram #(
  parameter int XLEN        = 32,
  parameter int XLEN_GRAN   = $clog2(XLEN / 8),
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [XLEN-1:XLEN_GRAN] addr_i,
  input  logic                    we_i,
  input  logic [XLEN/8-1:0]       sel_i,
  input  logic [XLEN-1:0]         dat_i,
  input  logic                    stb_i,
  input  logic                    cyc_i,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    stall_o,
  output logic [XLEN-1:0]         dat_o
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam int         NB       = XLEN / 8;
  localparam bit         NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;

  // Request captured at the accept edge when wait states are in use.
  logic [XLEN-1:XLEN_GRAN] addr_q;
  logic                    we_q;
  logic [NB-1:0]           sel_q;
  logic [XLEN-1:0]         dat_q;

  logic                    ack_r;
  logic                    err_r;

  logic [XLEN-1:0]         mem [DEPTH_WORDS];

  logic                    accept;
  logic                    exec;
  logic [XLEN-1:XLEN_GRAN] ex_addr;
  logic                    ex_we;
  logic [NB-1:0]           ex_sel;
  logic [XLEN-1:0]         ex_dat;
  logic [AW-1:0]           idx;
  logic                    oor;
  logic                    mem_we;

  assign stall_o = (state == ST_WAIT);
  assign accept  = cyc_i & stb_i & ~stall_o;

  // Without wait states the access happens at the accept edge straight from
  // the bus; otherwise it happens on the last WAIT edge from the latched copy,
  // and only if the master still holds the cycle.
  assign exec    = NO_WAIT ? accept
                           : ((state == ST_WAIT) && (cnt == 4'd1) && cyc_i);
  assign ex_addr = NO_WAIT ? addr_i : addr_q;
  assign ex_we   = NO_WAIT ? we_i   : we_q;
  assign ex_sel  = NO_WAIT ? sel_i  : sel_q;
  assign ex_dat  = NO_WAIT ? dat_i  : dat_q;
  assign idx     = ex_addr[AW+XLEN_GRAN-1:XLEN_GRAN];

`ifdef MR_WB_RAM_ERR_EN
  logic [XLEN-1:XLEN_GRAN] addr_hi;
  assign addr_hi = ex_addr >> AW;
  assign oor     = |addr_hi;
`else
  // Upper address bits alias onto the RAM; fold them into a sink.
  logic addr_hi_unused;
  assign addr_hi_unused = ^ex_addr;
  assign oor            = 1'b0;
`endif

  // Responses only show while the cycle is still held by the master.
  assign ack_o = ack_r & cyc_i;
  assign err_o = err_r & cyc_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      dat_q  <= '0;
      ack_r  <= 1'b0;
      err_r  <= 1'b0;
      dat_o  <= '0;
    end else begin
      ack_r <= exec & ~oor;
      err_r <= exec & oor;
      if (exec && !ex_we && !oor) begin
        dat_o <= mem[idx];
      end

      case (state)
        ST_IDLE: begin
          if (accept && !NO_WAIT) begin
            addr_q <= addr_i;
            we_q   <= we_i;
            sel_q  <= sel_i;
            dat_q  <= dat_i;
            cnt    <= CNT_LOAD;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Losing cyc_i abandons the access; cnt==1 is the execute edge.
          if (!cyc_i || cnt == 4'd1) begin
            cnt   <= 4'd0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          cnt   <= 4'd0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM array is not reset. The write is blocked while rst is asserted so a
  // request arriving during reset cannot land.
  assign mem_we = exec & ex_we & ~oor & ~rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (ex_sel[i]) begin
          mem[idx][8*i +: 8] <= ex_dat[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mr_wb_ram.sv
// tb/tb_mr_wb_ram.sv - randomized self-checking bench for mr_wb_ram (N=0 and N=3)
module tb_mr_wb_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] addr;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic        stb;
  logic        cyc0, cyc3;
  logic        ack0, err0, stall0;
  logic        ack3, err3, stall3;
  logic [31:0] rdat0, rdat3;

  int checks = 0;
  int errors = 0;

  // Reference model: one word array per instance plus the last value read.
  logic [31:0] mdl [2][1024];
  logic [31:0] lastrd [2];

  always #5 clk = ~clk;

  mr_wb_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .addr_i(addr), .we_i(we), .sel_i(sel), .dat_i(wdat),
    .stb_i(stb), .cyc_i(cyc0), .ack_o(ack0), .err_o(err0), .stall_o(stall0),
    .dat_o(rdat0)
  );

  mr_wb_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .addr_i(addr), .we_i(we), .sel_i(sel), .dat_i(wdat),
    .stb_i(stb), .cyc_i(cyc3), .ack_o(ack3), .err_o(err3), .stall_o(stall3),
    .dat_o(rdat3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic get_ack(input int w);
    return (w == 0) ? ack0 : ack3;
  endfunction
  function automatic logic get_err(input int w);
    return (w == 0) ? err0 : err3;
  endfunction
  function automatic logic get_stall(input int w);
    return (w == 0) ? stall0 : stall3;
  endfunction
  function automatic logic [31:0] get_dat(input int w);
    return (w == 0) ? rdat0 : rdat3;
  endfunction

  task automatic set_cyc(input int w, input logic v);
    if (w == 0) cyc0 = v;
    else        cyc3 = v;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_oor(input logic [29:0] a);
`ifdef MR_WB_RAM_ERR_EN
    return (a >= 30'd1024);
`else
    return 1'b0;
`endif
  endfunction

  // One isolated access on instance w (0 -> N=0, 1 -> N=3), fully checked.
  task automatic access(input int w, input logic wr, input logic [29:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    int          n;
    int          lat;
    int          stalls;
    logic        gack, gerr, after;
    logic [31:0] rd;
    bit          bad;
    n = (w == 0) ? 0 : 3;
    bad = is_oor(a);
    lat = 0; stalls = 0; gack = 0; gerr = 0; rd = 'x;
    @(posedge clk); #1;
    addr = a; we = wr; sel = s; wdat = d; stb = 1'b1; set_cyc(w, 1'b1);
    @(posedge clk); #1;
    stb = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (get_ack(w) || get_err(w)) begin
        lat = k; gack = get_ack(w); gerr = get_err(w); rd = get_dat(w);
        break;
      end
      if (get_stall(w)) stalls++;
    end
    @(negedge clk);
    after = get_ack(w) | get_err(w) | get_stall(w);
    set_cyc(w, 1'b0);
    if (!bad && wr) mdl[w][a[9:0]] = merge(mdl[w][a[9:0]], d, s);
    if (!bad && !wr) lastrd[w] = mdl[w][a[9:0]];
    check("latency", lat, n + 1);
    check("stall_cycles", stalls, n);
    check("ack", {31'd0, gack}, {31'd0, !bad});
    check("err", {31'd0, gerr}, {31'd0, bad});
    check("dat_o", rd, lastrd[w]);
    check("single_resp", {31'd0, after}, 32'd0);
  endtask

  logic [29:0] ra;
  logic [31:0] old7;
  int          hits;
  int          stalls;

  initial begin
    addr = '0; we = 0; sel = '0; wdat = '0; stb = 0; cyc0 = 0; cyc3 = 0;
    lastrd[0] = '0; lastrd[1] = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_ack0", {31'd0, ack0}, 0);
    check("rst_err0", {31'd0, err0}, 0);
    check("rst_stall0", {31'd0, stall0}, 0);
    check("rst_dat0", rdat0, 0);
    check("rst_ack3", {31'd0, ack3}, 0);
    check("rst_err3", {31'd0, err3}, 0);
    check("rst_stall3", {31'd0, stall3}, 0);
    check("rst_dat3", rdat3, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 32; i++) access(w, 1'b1, 30'(i), 4'hF, $urandom);

    // Full-word write/read and byte-lane merge on the zero-wait instance.
    access(0, 1'b1, 30'd5, 4'hF, 32'hDEADBEEF);
    access(0, 1'b0, 30'd5, 4'h0, 32'h0);
    check("deadbeef", rdat0, 32'hDEADBEEF);
    access(0, 1'b1, 30'd2, 4'hF, 32'h11223344);
    access(0, 1'b1, 30'd2, 4'h5, 32'hAABBCCDD);
    access(0, 1'b0, 30'd2, 4'hF, 32'h0);
    check("byte_lanes", rdat0, 32'h11BB33DD);
    access(0, 1'b1, 30'd2, 4'h0, 32'h55555555);
    access(0, 1'b0, 30'd2, 4'hF, 32'h0);
    check("sel_zero", rdat0, 32'h11BB33DD);

    // Back-to-back reads with one response per cycle.
    for (int i = 0; i < 4; i++) access(0, 1'b1, 30'(i), 4'hF, 32'(10 + i));
    @(posedge clk); #1;
    cyc0 = 1; stb = 1; we = 0; sel = 4'hF; addr = 30'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) addr = 30'(i + 1);
      else       stb = 0;
      @(negedge clk);
      check("b2b_ack", {31'd0, ack0}, 1);
      check("b2b_dat", rdat0, mdl[0][i]);
      check("b2b_dat_val", rdat0, 32'(10 + i));
    end
    @(negedge clk);
    check("b2b_end", {31'd0, ack0}, 0);
    cyc0 = 0;
    lastrd[0] = mdl[0][3];

    // Out-of-range / aliased word 1024 on both instances.
    access(0, 1'b0, 30'd1024, 4'hF, 32'h0);
    access(1, 1'b0, 30'd1024, 4'hF, 32'h0);

    // Wait states with stb held through the stall, and a second request
    // presented in the ack cycle.
    @(posedge clk); #1;
    cyc3 = 1; stb = 1; we = 0; addr = 30'd9;
    @(posedge clk); #1;
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (stall3 && !ack3) stalls++;
    end
    check("hold_stalls", stalls, 3);
    @(negedge clk);
    check("hold_ack", {31'd0, ack3}, 1);
    check("hold_stall_in_ack", {31'd0, stall3}, 0);
    check("hold_dat", rdat3, mdl[1][9]);
    addr = 30'd11;
    @(posedge clk); #1;
    stb = 0;
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (stall3 && !ack3) stalls++;
    end
    check("pipe_stalls", stalls, 3);
    @(negedge clk);
    check("pipe_ack", {31'd0, ack3}, 1);
    check("pipe_dat", rdat3, mdl[1][11]);
    @(negedge clk);
    check("pipe_idle", {31'd0, ack3 | stall3}, 0);
    cyc3 = 0;
    lastrd[1] = mdl[1][11];

    // Abort by dropping cyc in the second WAIT cycle.
    old7 = mdl[1][7];
    @(posedge clk); #1;
    cyc3 = 1; stb = 1; we = 1; addr = 30'd7; sel = 4'hF; wdat = 32'hCAFEF00D;
    @(posedge clk); #1; stb = 0;
    @(posedge clk); #1; cyc3 = 0;
    @(posedge clk); #1; cyc3 = 1;
    hits = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ack3 || err3) hits++;
    end
    check("abort_no_ack", hits, 0);
    check("abort_stall", {31'd0, stall3}, 0);
    cyc3 = 0;
    access(1, 1'b0, 30'd7, 4'hF, 32'h0);
    check("abort_word7", rdat3, old7);

    // Reset pulsed mid-WAIT.
    @(posedge clk); #1;
    cyc3 = 1; stb = 1; we = 1; addr = 30'd7; sel = 4'hF; wdat = 32'hCAFEF00D;
    @(posedge clk); #1; stb = 0;
    @(posedge clk); #1; rst = 1;
    #1;
    check("rstw_stall", {31'd0, stall3}, 0);
    check("rstw_ack", {31'd0, ack3}, 0);
    check("rstw_dat3", rdat3, 0);
    check("rstw_dat0", rdat0, 0);
    @(posedge clk); #1; rst = 0; cyc3 = 0;
    lastrd[0] = '0; lastrd[1] = '0;
    hits = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ack3 || stall3) hits++;
    end
    check("rstw_quiet", hits, 0);
    access(1, 1'b0, 30'd7, 4'hF, 32'h0);
    check("rstw_word7", rdat3, old7);

    // Randomized mix on both instances, including high address bits.
    for (int t = 0; t < 80; t++) begin
      ra = 30'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) ra[29:10] = 20'($urandom_range(1, 1000));
      access($urandom_range(0, 1), 1'($urandom_range(0, 1)), ra,
             4'($urandom_range(0, 15)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule

// File: doc/mr_wb_ram.md
# mr_wb_ram

Pipelined Wishbone B4 slave wrapping a single-port on-chip word RAM. It is the responder for the load/store unit's bus master and serves as data memory and scratchpad. It provides byte-lane writes, full-word reads, programmable wait states with `stall_o` back-pressure, and optional bus-error signalling for out-of-range addresses.

## Interface
- `DEPTH_WORDS`, 1024: RAM size in `XLEN`-bit words; must be a power of two.
- `WAIT_STATES`, 0: extra cycles per access, range 0–15.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `addr_i` in `XLEN-XLEN_GRAN`: word address, bits [`XLEN-1`:`XLEN_GRAN`].
- `we_i` in 1: 1 = write, 0 = read.
- `sel_i` in `XLEN/8`: byte-lane enables for writes.
- `dat_i` in `XLEN`: write data.
- `stb_i` in 1: request strobe.
- `cyc_i` in 1: bus cycle active.
- `ack_o` out 1: access completed.
- `err_o` out 1: access failed (out of range).
- `stall_o` out 1: request not accepted this cycle.
- `dat_o` out `XLEN`: read data, valid while `ack_o` is 1.

## Operation
- Acceptance: a request is accepted on a rising edge where `cyc_i & stb_i & !stall_o`.
- State machine: IDLE, WAIT.
- `WAIT_STATES==0`
  - State stays IDLE and `stall_o` is always 0.
  - The access executes at the accept edge.
  - The response is registered at the same edge.
- `WAIT_STATES==N>0`
  - At the accept edge: latch addr/we/sel/dat, load `cnt=N`, go to WAIT.
  - `stall_o = (state==WAIT)`.
  - Each WAIT edge decrements `cnt`.
  - At the edge where `cnt==1`: execute the access, register the response, return to IDLE.
- Write: for each lane `i` with `sel_i[i]`, set `mem[idx]` byte `i` from `dat_i` byte `i`. Unselected bytes are unchanged. `sel_i==0` writes nothing but still acks.
- Read: `dat_o <= mem[idx]` (full word, `sel` ignored). `dat_o` holds its value between reads and is not updated on writes or errors.
- `idx` = `addr_i[log2(DEPTH_WORDS)+XLEN_GRAN-1:XLEN_GRAN]`.
- Abort:
  - If `cyc_i==0` at the execute edge, the access is discarded: no write, no ack/err.
  - If `cyc_i` drops while in WAIT: go to IDLE immediately, with no access.
- `ack_o = ack_r & cyc_i` and `err_o = err_r & cyc_i` (combinational gate). `ack_r`/`err_r` are single-cycle pulses.
- `ack_o` and `err_o` are never both 1.
- Memory contents are not reset and are undefined at power-up.

## Timing
- Reset values (asynchronous, immediate): `ack_o=0`, `err_o=0`, `stall_o=0`, `dat_o=0`, state=IDLE, `cnt=0`.
- A pending access at reset is dropped with no write.
- Latency from accept edge to the ack/err cycle: N=0 → next cycle; N>0 → N+1 cycles later.
- `stall_o` is high for exactly N cycles per accepted request.
- Throughput:
  - N=0: one access per cycle; back-to-back acks in request order.
  - N>0: one access per N+1 cycles. A new request may be accepted in the ack cycle because `stall_o` is already 0.
- `stb_i` held high during stall is not re-accepted; it is accepted once `stall_o` falls.
- At most one access is outstanding when N>0; for N=0, one response is in flight.

## Configuration
- `MR_WB_RAM_ERR_EN` defined:
  - Any address bit above `idx` nonzero → `err_r` pulse with the normal latency.
  - No write; `dat_o` unchanged.
- `MR_WB_RAM_ERR_EN` undefined:
  - Upper address bits are ignored and addresses alias modulo `DEPTH_WORDS`.
  - `err_o` is tied to 0.

## Test plan
- N=0: write `0xDEADBEEF` to word 5 (`sel=1111`), then read word 5 → ack one cycle after each accept; `dat_o=0xDEADBEEF`; `stall_o` stays 0.
- Byte lanes: write `0x11223344` to word 2, then write `0xAABBCCDD` with `sel=0101`, then read word 2 → `0x11BB33DD`.
- N=3: read with `stb_i` held → `stall_o` high 3 cycles, ack on the 4th cycle after accept, exactly one ack; a second request presented in the ack cycle is accepted at that cycle's edge.
- N=0, 4 back-to-back reads of words 0–3 (preloaded 10,11,12,13) → `ack_o` high 4 consecutive cycles with `dat_o` 10,11,12,13.
- `DEPTH_WORDS=1024`, read word 1024:
  - With `MR_WB_RAM_ERR_EN` → `err_o=1` one cycle, `ack_o=0`, `dat_o` unchanged.
  - Without it → `ack_o=1`, data of word 0.
- N=3 write of `0xCAFEF00D` to word 7, drop `cyc_i` in the 2nd WAIT cycle → no ack; word 7 unchanged. Repeat with `rst` pulsed mid-WAIT → `stall_o` 0 immediately, no ack, word 7 unchanged.
